adder_result_bcd: RTL and testbench

Downstream result stage for the 4-bit carry-lookahead add/subtract unit. It captures the unit's `Sum`/`Cout` pair together with the `SEL` that produced it and forms a signed magnitude. It then converts the magnitude to two BCD digits with a sequential shift-add-3 (double-dabble) engine and drives two seven-segment digit patterns for the board display. It uses a single-pulse `load` / `busy` / `valid` handshake.

---
 rtl/adder_result_bcd.sv | 139 +++++++++++++
 tb/tb_adder_result_bcd.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adder_result_bcd.sv
// Result stage for the 4-bit add/subtract unit: captures Sum/Cout/SEL, forms a signed
// magnitude, converts it to two BCD digits by shift-add-3 and drives two 7-segment digits.
//
// state | meaning
// IDLE  | no result yet since reset, waiting for load
// CONV  | shift-add-3 conversion running, load ignored
// DONE  | tens/ones/neg hold a current result, load restarts
module adder_result_bcd #(
    parameter logic SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       SEL,
    input  logic       Cout,
    input  logic [3:0] Sum,
    output logic       busy,
    output logic       valid,
    output logic       neg,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t     state, state_nx;
    logic       accept;
    logic       last_shift;
    logic [4:0] mag_cap;
    logic       neg_cap;
    logic [4:0] mag_sr;
    logic       neg_pend;
    logic [7:0] work;
    logic [7:0] work_adj;
    logic [7:0] work_nx;
    logic [2:0] cnt;
    logic       unused_adj_msb;

    // Borrow on subtract means the adder produced 16 - |result| in Sum.
    always_comb begin
        mag_cap = {Cout, Sum};
        neg_cap = 1'b0;
        if (SEL) begin
            if (Cout) begin
                mag_cap = {1'b0, Sum};
            end else begin
                mag_cap = {1'b0, ~Sum} + 5'd1;
                neg_cap = 1'b1;
            end
        end
    end

    assign work_adj[7:4]  = (work[7:4] >= 4'd5) ? work[7:4] + 4'd3 : work[7:4];
    assign work_adj[3:0]  = (work[3:0] >= 4'd5) ? work[3:0] + 4'd3 : work[3:0];
    // Magnitude never exceeds 31, so the adjusted MSB is always shifted out as zero.
    assign work_nx        = {work_adj[6:0], mag_sr[4]};
    assign unused_adj_msb = work_adj[7];
    assign last_shift     = (cnt == 3'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        valid    = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    accept   = 1'b1;
                    state_nx = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (last_shift) state_nx = DONE;
            end
            DONE: begin
                valid = 1'b1;
                if (load) begin
                    accept   = 1'b1;
                    state_nx = CONV;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_sr   <= '0;
            neg_pend <= 1'b0;
            work     <= '0;
            cnt      <= '0;
            tens     <= '0;
            ones     <= '0;
            neg      <= 1'b0;
        end else if (accept) begin
            mag_sr   <= mag_cap;
            neg_pend <= neg_cap;
            work     <= '0;
            cnt      <= '0;
        end else if (state == CONV) begin
            work   <= work_nx;
            mag_sr <= {mag_sr[3:0], 1'b0};
            cnt    <= cnt + 3'd1;
            if (last_shift) begin
                tens <= work_nx[7:4];
                ones <= work_nx[3:0];
                neg  <= neg_pend;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    assign seg_tens = SEG_ACTIVE_LOW ? ~seg7(tens) : seg7(tens);
    assign seg_ones = SEG_ACTIVE_LOW ? ~seg7(ones) : seg7(ones);

endmodule

// File: tb/tb_adder_result_bcd.sv
// Directed and randomized bench for adder_result_bcd; expected digits come from plain
// arithmetic on the signed add/subtract result, never from the conversion steps.
module tb_adder_result_bcd;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       SEL;
    logic       Cout;
    logic [3:0] Sum;
    logic       busy;
    logic       valid;
    logic       neg;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;

    int         checks = 0;
    int         errors = 0;
    int         exp_tens = 0;
    int         exp_ones = 0;
    int         exp_neg = 0;

    adder_result_bcd #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .SEL      (SEL),
        .Cout     (Cout),
        .Sum      (Sum),
        .busy     (busy),
        .valid    (valid),
        .neg      (neg),
        .tens     (tens),
        .ones     (ones),
        .seg_tens (seg_tens),
        .seg_ones (seg_ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Active-low display patterns, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_model(input int d);
        logic [6:0] hi;
        case (d)
            0: hi = 7'h3F;
            1: hi = 7'h06;
            2: hi = 7'h5B;
            3: hi = 7'h4F;
            4: hi = 7'h66;
            5: hi = 7'h6D;
            6: hi = 7'h7D;
            7: hi = 7'h07;
            8: hi = 7'h7F;
            9: hi = 7'h6F;
            default: hi = 7'h00;
        endcase
        return ~hi;
    endfunction

    // Magnitude of the add/subtract result the adder outputs describe.
    task automatic model(input logic s, input logic c, input logic [3:0] sm);
        int m;
        if (!s)      begin m = 16 * int'(c) + int'(sm); exp_neg = 0; end
        else if (c)  begin m = int'(sm);                exp_neg = 0; end
        else         begin m = 16 - int'(sm);           exp_neg = 1; end
        exp_tens = m / 10;
        exp_ones = m % 10;
    endtask

    task automatic check_all(input string tag, input logic b, input logic v);
        check({tag, ".busy"},     32'(busy),     32'(b));
        check({tag, ".valid"},    32'(valid),    32'(v));
        check({tag, ".tens"},     32'(tens),     32'(exp_tens));
        check({tag, ".ones"},     32'(ones),     32'(exp_ones));
        check({tag, ".neg"},      32'(neg),      32'(exp_neg));
        check({tag, ".seg_tens"}, 32'(seg_tens), 32'(seg_model(exp_tens)));
        check({tag, ".seg_ones"}, 32'(seg_ones), 32'(seg_model(exp_ones)));
    endtask

    // Full conversion: load on the next edge (E0), old result holds through E4, new at E5.
    task automatic conv(input logic s, input logic c, input logic [3:0] sm, input string tag);
        @(negedge clk);
        load = 1'b1; SEL = s; Cout = c; Sum = sm;
        @(posedge clk); #1;
        load = 1'b0;
        SEL = 1'($urandom); Cout = 1'($urandom); Sum = 4'($urandom);
        check_all({tag, ".e0"}, 1'b1, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
            check({tag, ".conv_busy"},  32'(busy),  32'd1);
            check({tag, ".conv_valid"}, 32'(valid), 32'd0);
            check({tag, ".conv_tens"},  32'(tens),  32'(exp_tens));
        end
        @(posedge clk); #1;
        model(s, c, sm);
        check_all({tag, ".e5"}, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; SEL = 1'b0; Cout = 1'b0; Sum = 4'd0;
        #2;
        check_all("reset", 1'b0, 1'b0);
        check("reset.seg_raw", 32'(seg_ones), 32'h40);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_all("idle", 1'b0, 1'b0);

        conv(1'b0, 1'b0, 4'd10, "add10");
        check("add10.seg_tens_raw", 32'(seg_tens), 32'h79);
        conv(1'b0, 1'b1, 4'd14, "add30");
        conv(1'b0, 1'b1, 4'd0,  "add16");
        conv(1'b0, 1'b1, 4'd15, "add31");
        conv(1'b1, 1'b1, 4'd0,  "sub0");
        conv(1'b1, 1'b0, 4'd14, "subm2");
        conv(1'b1, 1'b0, 4'd0,  "subm16");

        repeat (10) @(posedge clk);
        #1;
        check_all("done_hold", 1'b0, 1'b1);

        // Loads during CONV, including the completing edge, are dropped.
        @(negedge clk);
        load = 1'b1; SEL = 1'b0; Cout = 1'b0; Sum = 4'd10;
        @(posedge clk); #1;
        load = 1'b0;
        check_all("hs.e0", 1'b1, 1'b0);
        @(posedge clk); #1;
        load = 1'b1; Sum = 4'd3;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        load = 1'b1; Sum = 4'd3;
        @(posedge clk); #1;
        load = 1'b0;
        model(1'b0, 1'b0, 4'd10);
        check_all("hs.e5", 1'b0, 1'b1);
        @(posedge clk); #1;
        check_all("hs.e6", 1'b0, 1'b1);

        // Abort in the 3rd CONV cycle.
        @(negedge clk);
        load = 1'b1; SEL = 1'b0; Cout = 1'b1; Sum = 4'd9;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_tens = 0; exp_ones = 0; exp_neg = 0;
        check_all("rst_mid", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        conv(1'b0, 1'b1, 4'd5, "after_rst");

        for (int i = 0; i < 25; i++) begin
            conv(1'($urandom), 1'($urandom), 4'($urandom), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
